mem_responder: RTL
==================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the MemIO port driven by the tag cache.
//  - Accepts req_cmd, collects req_data beats for writes, returns resp beats for reads.
//  - Backs requests with an internal line-organised array.
//  - Used as the synthesisable backing store in tag-cache test harnesses.
// PARAMETERS
//  ADDR_WIDTH   26   line (block) address width of mem_cmd_addr
//  TAG_WIDTH     5   transaction tag width, echoed on responses
//  DATA_WIDTH  128   width of one data beat
//  DATA_BEATS    4   beats per line (power of 2, >=2)
//  DEPTH_LINES 256   lines stored (power of 2); IDX_W = log2(DEPTH_LINES)
//  READ_LATENCY  2   idle cycles from read cmd handshake to first resp beat (>=1)
// PORTS
//  clk             in   1           clock, all state on rising edge
//  reset           in   1           asynchronous, active-low (0 = in reset)
//  mem_cmd_valid   in   1           command valid
//  mem_cmd_ready   out  1           command accepted when valid&ready
//  mem_cmd_addr    in   ADDR_WIDTH  line address
//  mem_cmd_tag     in   TAG_WIDTH   transaction tag
//  mem_cmd_rw      in   1           1 = write, 0 = read
//  mem_data_valid  in   1           write beat valid
//  mem_data_ready  out  1           write beat accepted when valid&ready
//  mem_data_data   in   DATA_WIDTH  write beat payload
//  mem_resp_valid  out  1           read beat valid (no backpressure)
//  mem_resp_data   out  DATA_WIDTH  read beat payload
//  mem_resp_tag    out  TAG_WIDTH   tag of the originating read
// BEHAVIOUR
//  Reset (reset==0, async)
//  - state=IDLE, beat=0.
//  - Outputs: mem_cmd_ready=1, mem_data_ready=0, mem_resp_valid=0, resp_data/tag=0.
//  - Array contents are neither cleared nor altered by reset.
//  FSM states: IDLE, WDATA, RWAIT, RDATA; one transaction at a time.
//  IDLE
//  - cmd_ready=1, data_ready=0.
//  - On cmd fire: latch idx=addr[IDX_W-1:0] (upper bits ignored, aliasing) and tag.
//  - rw=1 -> WDATA; rw=0 -> RWAIT with cnt=READ_LATENCY-1.
//  - data_valid in IDLE is not accepted; data beats always follow their cmd.
//  WDATA
//  - cmd_ready=0, data_ready=1.
//  - Each data fire writes mem[{idx,beat}] and increments beat.
//  - Fire with beat==DATA_BEATS-1: beat wraps to 0, -> IDLE.
//  - Gaps in data_valid stall without timeout.
//  RWAIT
//  - cmd_ready=0. Decrements cnt each cycle; cnt==0 -> RDATA.
//  RDATA
//  - resp_valid=1 for exactly DATA_BEATS consecutive cycles.
//  - resp_data=mem[{idx,beat}], resp_tag=latched tag; all resp outputs registered.
//  - After last beat: resp_valid=0 next cycle, -> IDLE.
//  Timing
//  - Read cmd fire in cycle C: first resp beat in cycle C+READ_LATENCY+1, last beat in C+READ_LATENCY+DATA_BEATS.
//  - Next cmd accepted the cycle after the last beat (read) or the cycle after the last data fire (write).
//  - No same-cycle turnaround; cmd_ready is 0 in every non-IDLE state.
//  Hazards
//  - Read after write to the same idx returns the newly written data.
//  - Reading a never-written line returns undefined data; benches write first.
//  Reset mid-operation
//  - Immediate return to IDLE; remaining resp beats are dropped.
//  - Write beats already accepted stay in the array; the partial line is not rolled back.
// TESTING
//  1. Write addr 0x10, tag 3, beats 0xA0..0xA3, then read addr 0x10, tag 5 -> 4 beats 0xA0..0xA3, tag 5, first beat at cmd+3 cycles.
//  2. Write with data_valid low 2 cycles between beats -> data_ready held 1, cmd_ready 0 until 4th beat fires.
//  3. cmd_valid held high during a read response -> cmd_ready stays 0; second cmd accepted the cycle after last beat.
//  4. Write addr 0x110 (DEPTH 256), read addr 0x10 -> returns 0x110's data (aliasing).
//  5. Drop reset to 0 during RDATA after beat 1 -> resp_valid 0 immediately, cmd_ready 1, no further beats after release.
//  6. Back-to-back write and read, 8 random lines vs scoreboard -> all beats and tags match, no beat reordering.

Source files
------------

// File: rtl/mem_responder_if.sv
// mem_responder_if: MemIO bundle between the tag cache (master) and the memory responder (slave)
// Signals:
//   mem_cmd_valid/ready/addr/tag/rw  command channel (rw: 1 = write, 0 = read)
//   mem_data_valid/ready/data        write-data beats, always following their command
//   mem_resp_valid/data/tag          read-data beats, no backpressure
interface mem_responder_if #(
    parameter int ADDR_WIDTH = 26,
    parameter int TAG_WIDTH  = 5,
    parameter int DATA_WIDTH = 128
);
    logic                  mem_cmd_valid;
    logic                  mem_cmd_ready;
    logic [ADDR_WIDTH-1:0] mem_cmd_addr;
    logic [TAG_WIDTH-1:0]  mem_cmd_tag;
    logic                  mem_cmd_rw;
    logic                  mem_data_valid;
    logic                  mem_data_ready;
    logic [DATA_WIDTH-1:0] mem_data_data;
    logic                  mem_resp_valid;
    logic [DATA_WIDTH-1:0] mem_resp_data;
    logic [TAG_WIDTH-1:0]  mem_resp_tag;
    modport master (
        output mem_cmd_valid, mem_cmd_addr, mem_cmd_tag, mem_cmd_rw, mem_data_valid, mem_data_data,
        input  mem_cmd_ready, mem_data_ready, mem_resp_valid, mem_resp_data, mem_resp_tag
    );
    modport slave (
        input  mem_cmd_valid, mem_cmd_addr, mem_cmd_tag, mem_cmd_rw, mem_data_valid, mem_data_data,
        output mem_cmd_ready, mem_data_ready, mem_resp_valid, mem_resp_data, mem_resp_tag
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: line-organised backing store answering MemIO commands, one transaction at a time
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset; array contents survive it
//   bus    mem_responder_if.slave: accepts commands, collects DATA_BEATS write beats,
//          returns DATA_BEATS registered read beats READ_LATENCY+1 cycles after the read command
module mem_responder #(
    parameter int ADDR_WIDTH   = 26,
    parameter int TAG_WIDTH    = 5,
    parameter int DATA_WIDTH   = 128,
    parameter int DATA_BEATS   = 4,
    parameter int DEPTH_LINES  = 256,
    parameter int READ_LATENCY = 2
) (
    input logic            clk,
    input logic            reset,
    mem_responder_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_LINES);
    localparam int BW    = $clog2(DATA_BEATS);
    localparam int CW    = $clog2(READ_LATENCY + 1);
    localparam logic [BW-1:0] LAST = BW'(DATA_BEATS - 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WDATA = 2'd1;
    localparam logic [1:0] RWAIT = 2'd2;
    localparam logic [1:0] RDATA = 2'd3;
    logic [1:0]            state;
    logic [BW-1:0]         beat;
    logic [BW-1:0]         nxt;
    logic [CW-1:0]         cnt;
    logic [IDX_W-1:0]      idx;
    logic [TAG_WIDTH-1:0]  tag;
    logic                  data_fire;
    logic [DATA_WIDTH-1:0] mem [DEPTH_LINES*DATA_BEATS];
    assign bus.mem_cmd_ready  = state == IDLE;
    assign bus.mem_data_ready = state == WDATA;
    assign data_fire          = bus.mem_data_valid && state == WDATA;
    assign nxt                = beat + 1'b1;
    // The array has no reset so that written lines persist across resets.
    always_ff @(posedge clk)
        if (data_fire) mem[{idx, beat}] <= bus.mem_data_data;
    // beat wraps to 0 naturally after LAST, leaving it ready for the next transaction.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state              <= IDLE;
            beat               <= '0;
            cnt                <= '0;
            idx                <= '0;
            tag                <= '0;
            bus.mem_resp_valid <= 1'b0;
            bus.mem_resp_data  <= '0;
            bus.mem_resp_tag   <= '0;
        end else begin
            case (state)
                IDLE: if (bus.mem_cmd_valid) begin
                    idx   <= bus.mem_cmd_addr[IDX_W-1:0];
                    tag   <= bus.mem_cmd_tag;
                    cnt   <= CW'(READ_LATENCY - 1);
                    state <= bus.mem_cmd_rw ? WDATA : RWAIT;
                end
                WDATA: if (bus.mem_data_valid) begin
                    beat  <= nxt;
                    state <= beat == LAST ? IDLE : WDATA;
                end
                RWAIT: if (cnt == '0) begin
                    state              <= RDATA;
                    bus.mem_resp_valid <= 1'b1;
                    bus.mem_resp_data  <= mem[{idx, beat}];
                    bus.mem_resp_tag   <= tag;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                default: begin
                    beat <= nxt;
                    if (beat == LAST) begin
                        state              <= IDLE;
                        bus.mem_resp_valid <= 1'b0;
                        bus.mem_resp_data  <= '0;
                        bus.mem_resp_tag   <= '0;
                    end else begin
                        bus.mem_resp_data <= mem[{idx, nxt}];
                    end
                end
            endcase
        end
endmodule
